// File: rtl/monolith_pkg.sv
// rtl/monolith_pkg.sv - shared M31 types, scheduler states and input canonicalisation
package monolith_pkg;

  localparam logic [31:0] M31_P = 32'h7FFF_FFFF;
  localparam int MONO_FELT_W = 31;

  typedef logic [MONO_FELT_W-1:0] felt_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } sched_state_t;

  // The all-ones encoding is the prime itself, so it folds back to zero.
  function automatic felt_t canonicalise(input felt_t x);
    return (x == M31_P[MONO_FELT_W-1:0]) ? '0 : x;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  // Walk distances 0..N-1 from the pointer; the first requester found wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_valid && req[i] &&
            (((i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_REQ - int'(ptr))) == k)) begin
          grant_valid = 1'b1;
          grant[i]    = 1'b1;
          grant_idx   = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/monolith_job_scheduler.sv
// rtl/monolith_job_scheduler.sv - one-at-a-time job scheduler in front of a shared monolith hash core
module monolith_job_scheduler
  import monolith_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FELT_W      = 31,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*FELT_W-1:0]   req_in1,
  input  logic [NUM_REQ*FELT_W-1:0]   req_in2,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [FELT_W-1:0]           rsp_data,
  output logic                        rsp_err,
  output logic                        core_start,
  output logic [FELT_W-1:0]           core_in1,
  output logic [FELT_W-1:0]           core_in2,
  input  logic                        core_valid,
  input  logic [FELT_W-1:0]           core_out,
  output logic [31:0]                 jobs_done,
  output logic [15:0]                 timeout_cnt,
  output logic                        busy
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_t       state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   wd_cnt;
  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic [FELT_W-1:0]  sel_in1;
  logic [FELT_W-1:0]  sel_in2;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant_oh),
    .grant_idx   (grant_idx),
    .grant_valid (grant_any)
  );

  // Accept is only offered while idle; the transfer completes in that same cycle.
  assign req_ready = (state == IDLE) ? grant_oh : '0;

  // Pick the granted requester's operands out of the packed input buses.
  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_in1 = req_in1[i*FELT_W +: FELT_W];
        sel_in2 = req_in2[i*FELT_W +: FELT_W];
      end
    end
  end

  // Job sequencer: accept, launch, watch the core, hold the response until taken.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      core_start  <= 1'b0;
      core_in1    <= '0;
      core_in2    <= '0;
      jobs_done   <= '0;
      timeout_cnt <= '0;
      busy        <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_any) begin
            core_in1   <= FELT_W'(canonicalise(felt_t'(sel_in1)));
            core_in2   <= FELT_W'(canonicalise(felt_t'(sel_in2)));
            rsp_id     <= grant_idx;
            core_start <= 1'b1;
            busy       <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (core_valid) begin
            rsp_data  <= core_out;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wd_cnt == LAST_CNT) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            if (timeout_cnt != 16'hFFFF) begin
              timeout_cnt <= timeout_cnt + 16'd1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            jobs_done <= jobs_done + 32'd1;
            rr_ptr    <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_monolith_job_scheduler.sv
// tb/tb_monolith_job_scheduler.sv - scoreboard bench for monolith_job_scheduler
module tb_monolith_job_scheduler;

  localparam int N  = 4;
  localparam int W  = 31;
  localparam int TO = 16;

  logic             aclk = 1'b0;
  logic             aresetn;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_in1;
  logic [N*W-1:0]   req_in2;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_data;
  logic             rsp_err;
  logic             core_start;
  logic [W-1:0]     core_in1;
  logic [W-1:0]     core_in2;
  logic             core_valid = 1'b0;
  logic [W-1:0]     core_out = '0;
  logic [31:0]      jobs_done;
  logic [15:0]      timeout_cnt;
  logic             busy;

  typedef struct {
    int         id;
    logic [W-1:0] data;
    logic       err;
  } exp_t;

  int     tests = 0;
  int     fails = 0;
  exp_t   sb[$];
  int     glog[$];
  int     exp_ptr = 0;
  int     core_lat = 0;
  int     cd = 0;
  int     mg;
  exp_t   me;
  logic [W-1:0] model_out = '0;

  monolith_job_scheduler #(
    .NUM_REQ     (N),
    .FELT_W      (W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_in1     (req_in1),
    .req_in2     (req_in2),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .core_start  (core_start),
    .core_in1    (core_in1),
    .core_in2    (core_in2),
    .core_valid  (core_valid),
    .core_out    (core_out),
    .jobs_done   (jobs_done),
    .timeout_cnt (timeout_cnt),
    .busy        (busy)
  );

  always #5 aclk = ~aclk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] canon(input logic [W-1:0] x);
    return (x == {W{1'b1}}) ? '0 : x;
  endfunction

  function automatic logic [W-1:0] hash(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a ^ {b[W-4:0], 3'b101}) + 31'h0123_4567;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic sample();
    @(negedge aclk);
  endtask

  task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask

  task automatic rand_slots();
    for (int i = 0; i < N; i++) begin
      set_slot(i, ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom), W'($urandom));
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    sb.delete();
    glog.delete();
    exp_ptr = 0;
  endtask

  // Counts cycles after the core_start cycle until rsp_valid is seen.
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      step();
      n++;
      sample();
      if (n == 1) check("start_once", core_start, 0);
    end while (!rsp_valid && n < 60);
  endtask

  task automatic wait_jobs(input string tag, input int target);
    int n;
    n = 0;
    while (jobs_done != 32'(target) && n < 300) begin
      step();
      n++;
      sample();
    end
    check(tag, jobs_done, target);
  endtask

  // Core stub: pulses core_valid core_lat cycles after core_start (never if 0).
  always begin
    @(posedge aclk);
    #1;
    core_valid = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        core_valid = 1'b1;
        core_out   = model_out;
      end
    end
    if (core_start && core_lat > 0) begin
      cd        = core_lat;
      model_out = hash(core_in1, core_in2);
    end
  end

  // Scoreboard: push on accept, pop and compare on response handshake.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (req_ready != '0) begin
        mg = -1;
        for (int k = 0; k < N; k++) begin
          if (mg < 0 && req_valid[(exp_ptr + k) % N]) mg = (exp_ptr + k) % N;
        end
        check("grant_onehot", 32'(req_ready), (mg < 0) ? 32'd0 : (32'd1 << mg));
        for (int k = 0; k < N; k++) begin
          if (req_ready[k]) glog.push_back(k);
        end
        if (mg >= 0) begin
          me.id   = mg;
          me.err  = (core_lat == 0 || core_lat > TO);
          me.data = me.err ? '0 : hash(canon(req_in1[mg*W +: W]), canon(req_in2[mg*W +: W]));
          sb.push_back(me);
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          me = sb.pop_front();
          check("rsp_id", rsp_id, me.id);
          check("rsp_data", rsp_data, me.data);
          check("rsp_err", rsp_err, me.err);
          exp_ptr = (me.id + 1) % N;
        end
      end
    end
  end

  int n;
  int rr_a[5] = '{0, 1, 2, 3, 0};
  int rr_b[3] = '{1, 3, 1};

  initial begin
    aresetn   = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_in1   = '0;
    req_in2   = '0;
    step();
    step();
    sample();
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_timeout_cnt", timeout_cnt, 0);
    check("rst_core_in1", core_in1, 0);
    check("rst_rsp_id", rsp_id, 0);

    // Single job
    step();
    aresetn   = 1'b1;
    core_lat  = 10;
    set_slot(0, 31'd1965742212, 31'd0);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    sample();
    check("t1_req_ready", req_ready, 4'b0001);
    check("t1_no_early_start", core_start, 0);
    step();
    req_valid = '0;
    sample();
    check("t1_core_start", core_start, 1);
    check("t1_core_in1", core_in1, 31'd1965742212);
    check("t1_core_in2", core_in2, 0);
    check("t1_busy", busy, 1);
    wait_rsp(n);
    check("t1_latency", n, 11);
    step();
    sample();
    check("t1_jobs_done", jobs_done, 1);
    check("t1_rsp_drop", rsp_valid, 0);
    check("t1_idle", busy, 0);

    // Round robin, all requesting then a sparse pattern
    do_reset();
    core_lat  = 3;
    rsp_ready = 1'b1;
    rand_slots();
    req_valid = 4'b1111;
    n = 0;
    while (glog.size() < 5 && n < 200) begin
      step();
      rand_slots();
      n++;
      sample();
    end
    step();
    req_valid = '0;
    wait_jobs("rr_jobs_a", 5);
    check("rr_count_a", glog.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_a%0d", i), (i < glog.size()) ? glog[i] : -1, rr_a[i]);
    end
    glog.delete();
    step();
    req_valid = 4'b1010;
    n = 0;
    while (glog.size() < 3 && n < 200) begin
      step();
      rand_slots();
      n++;
      sample();
    end
    step();
    req_valid = '0;
    wait_jobs("rr_jobs_b", 8);
    check("rr_count_b", glog.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rr_b%0d", i), (i < glog.size()) ? glog[i] : -1, rr_b[i]);
    end

    // Timeout, then backpressure with a late core_valid
    step();
    core_lat  = 20;
    rsp_ready = 1'b0;
    set_slot(2, 31'd77, 31'd88);
    req_valid = 4'b0100;
    sample();
    check("to_req_ready", req_ready, 4'b0100);
    step();
    req_valid = 4'b1111;
    sample();
    check("to_core_start", core_start, 1);
    wait_rsp(n);
    check("to_latency", n, 17);
    check("to_err", rsp_err, 1);
    check("to_data", rsp_data, 0);
    check("to_id", rsp_id, 2);
    check("to_timeout_cnt", timeout_cnt, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      sample();
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 2);
      check("bp_data", rsp_data, 0);
      check("bp_err", rsp_err, 1);
      check("bp_req_ready", req_ready, 0);
      check("bp_core_start", core_start, 0);
    end
    core_lat = 5;
    step();
    rsp_ready = 1'b1;
    sample();
    check("bp_jobs_before", jobs_done, 8);
    step();
    sample();
    check("bp_next_grant", req_ready, 4'b1000);
    check("bp_jobs_after", jobs_done, 9);
    step();
    req_valid = '0;
    sample();
    check("bp_core_start2", core_start, 1);
    wait_rsp(n);
    check("bp_latency", n, 6);
    step();
    sample();
    check("bp_jobs_done", jobs_done, 10);
    check("bp_timeout_cnt", timeout_cnt, 1);

    // Canonicalisation and valid/timeout collision
    step();
    core_lat = TO;
    set_slot(0, {W{1'b1}}, 31'd5);
    req_valid = 4'b0001;
    sample();
    check("cc_req_ready", req_ready, 4'b0001);
    step();
    req_valid = '0;
    sample();
    check("cc_core_in1", core_in1, 0);
    check("cc_core_in2", core_in2, 5);
    wait_rsp(n);
    check("cc_latency", n, 17);
    check("cc_err", rsp_err, 0);
    check("cc_timeout_cnt", timeout_cnt, 1);
    step();
    sample();
    check("cc_jobs_done", jobs_done, 11);

    // Reset in the middle of WAIT
    step();
    core_lat = 8;
    req_valid = 4'b0010;
    sample();
    check("rs_req_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    sample();
    check("rs_core_start", core_start, 1);
    step();
    step();
    step();
    aresetn = 1'b0;
    sample();
    step();
    aresetn = 1'b1;
    sb.delete();
    exp_ptr = 0;
    sample();
    check("rs_busy", busy, 0);
    check("rs_rsp_valid", rsp_valid, 0);
    check("rs_core_start_low", core_start, 0);
    check("rs_jobs_done", jobs_done, 0);
    check("rs_timeout_cnt", timeout_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      sample();
      check("rs_no_rsp", rsp_valid, 0);
      check("rs_stay_idle", busy, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
